// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch front end: RV32I major opcodes,
// the canonical NOP word and the fetch-state encoding.
package instr_fetch_pkg;

  localparam logic [4:0]  OPC_LOAD   = 5'b00000;
  localparam logic [4:0]  OPC_OP_IMM = 5'b00100;
  localparam logic [4:0]  OPC_STORE  = 5'b01000;
  localparam logic [4:0]  OPC_OP     = 5'b01100;
  localparam logic [4:0]  OPC_LUI    = 5'b01101;
  localparam logic [4:0]  OPC_BRANCH = 5'b11000;
  localparam logic [4:0]  OPC_JALR   = 5'b11001;
  localparam logic [4:0]  OPC_JAL    = 5'b11011;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem read at a time, result parked in the
// instruction register and presented to the decoder as split RV32I fields.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [4:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] instr_pc,
  output logic            illegal
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            req_q, req_d;
  logic            vld_q, vld_d;

  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] pc_inc_s;
  logic            unused_ok_s;

  assign target_s    = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc_s    = pc_q + XLEN'(4);
  assign unused_ok_s = ^redirect_pc[1:0];

  // Next-state, PC and IR update; redirect outranks every other event
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ipc_d   = ipc_q;
    if (redirect) begin
      pc_d = target_s;
      case (state_q)
        ST_REQ:  state_d = imem_gnt    ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = imem_rvalid ? ST_REQ  : ST_DROP;
        // An accepted read is still in flight; keep waiting so it cannot alias a new fetch.
        ST_DROP: state_d = imem_rvalid ? ST_REQ  : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (imem_gnt) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            ir_d    = imem_rdata;
            ipc_d   = pc_q;
            pc_d    = pc_inc_s;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    req_d = (state_d == ST_REQ);
    vld_d = (state_d == ST_HOLD);
  end

  // Fetch state, PC, IR and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
      ir_q    <= XLEN'(NOP_INSTR);
      ipc_q   <= {RESET_PC[XLEN-1:2], 2'b00};
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ipc_q   <= ipc_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = vld_q;
  assign instr_pc    = ipc_q;

  assign opcode = ir_q[6:2];
  assign rd     = ir_q[11:7];
  assign func3  = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign func7  = ir_q[31:25];

  assign illegal = vld_q & (ir_q[1:0] != 2'b11);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized run with an
// imem responder model and a scoreboard of the expected consumed instruction stream.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [4:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] instr_pc;
  logic        illegal;

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .instr_pc(instr_pc), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  int total = 0;
  int bad = 0;
  int n_cons = 0;
  bit sb_en = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] model_pc;

  logic        mon_req_prev = 1'b0;
  logic        mon_gnt_prev = 1'b0;
  logic        mon_redir_prev = 1'b0;
  logic [31:0] mon_addr_prev = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] field_bits();
    return 32'({func7, rs2, rs1, func3, rd, opcode});
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] w;
    if (!mem.exists(addr)) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[1:0] = 2'b11;
      mem[addr] = w;
    end
    return mem[addr];
  endfunction

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 4) begin
      e.pc   = model_pc;
      e.word = mem_word(model_pc);
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
  endtask

  // Waits for a request, grants it, returns the word one cycle later.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
    int n = 0;
    logic [31:0] w;
    w = word;
    while (!imem_req && n < 10) begin
      step();
      n++;
    end
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, imem_addr, addr);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check({tag, "_wait_novalid"}, 32'(instr_valid), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    step();
    imem_rvalid = 1'b0;
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_ipc"}, instr_pc, addr);
    check({tag, "_fields"}, field_bits(), 32'(w[31:2]));
  endtask

  // Scoreboard monitor: pops one expected instruction per consumption
  always @(negedge clk) begin
    if (sb_en) begin
      if (instr_valid && instr_ready && !redirect) begin
        n_cons++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got pc %h, expected no instruction", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_pc", instr_pc, mon_e.pc);
          check("sb_fields", field_bits(), 32'(mon_e.word[31:2]));
          check("sb_illegal", 32'(illegal), 32'(mon_e.word[1:0] != 2'b11));
        end
      end
      if (instr_valid) check("sb_hold_noreq", 32'(imem_req), 32'd0);
      if (imem_req) check("sb_align", 32'(imem_addr[1:0]), 32'd0);
      if (imem_req && mon_req_prev && !mon_gnt_prev && !mon_redir_prev)
        check("sb_addr_stable", imem_addr, mon_addr_prev);
    end
    mon_req_prev   = imem_req;
    mon_gnt_prev   = imem_gnt;
    mon_redir_prev = redirect;
    mon_addr_prev  = imem_addr;
  end

  initial begin
    logic        outst;
    logic [31:0] out_addr;
    int          cnt;
    logic        req_prev, gnt_prev;
    logic [31:0] addr_prev, tgt;

    // 1: reset values, then first fetch from RESET_PC
    repeat (3) step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_opcode", 32'(opcode), 32'(OPC_OP_IMM));
    check("rst_ipc", instr_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    rst = 1'b1;
    do_fetch("t1", 32'h0, 32'h0000_0013);
    check("t1_opcode", 32'(opcode), 32'h04);
    check("t1_illegal", 32'(illegal), 32'd0);

    // 2: add then sub
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    do_fetch("t2_add", 32'h4, 32'h0020_8033);
    check("t2_add_f7", 32'(func7), 32'h00);
    check("t2_add_f3", 32'(func3), 32'h0);
    check("t2_add_op", 32'(opcode), 32'(OPC_OP));
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    do_fetch("t2_sub", 32'h8, 32'h4020_8033);
    check("t2_sub_f7", 32'(func7), 32'h20);

    // 3: backpressure holds the IR and blocks fetch
    for (int i = 0; i < 5; i++) begin
      check("t3_valid", 32'(instr_valid), 32'd1);
      check("t3_noreq", 32'(imem_req), 32'd0);
      check("t3_ipc", instr_pc, 32'h8);
      check("t3_fields", field_bits(), 32'h1008_200C);
      step();
    end
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    do_fetch("t3_next", 32'hC, 32'h0050_0093);

    // 4: redirect in WAIT, stale data dropped
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    check("t4_addr16", imem_addr, 32'h10);
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100; step(); redirect = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_rvalid = 1'b0;
    check("t4_novalid", 32'(instr_valid), 32'd0);
    step();
    check("t4_novalid2", 32'(instr_valid), 32'd0);
    check("t4_req", 32'(imem_req), 32'd1);
    check("t4_addr", imem_addr, 32'h100);
    do_fetch("t4_fetch", 32'h100, 32'h00C5_0533);

    // 5: redirect beats instr_ready, low address bits forced to zero
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h203; step();
    instr_ready = 1'b0; redirect = 1'b0;
    check("t5_novalid", 32'(instr_valid), 32'd0);
    check("t5_addr", imem_addr, 32'h200);

    // 6: illegal encoding and PC wrap
    do_fetch("t6_ill", 32'h200, 32'h0000_0000);
    check("t6_illegal", 32'(illegal), 32'd1);
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; step(); redirect = 1'b0;
    do_fetch("t6_top", 32'hFFFF_FFFC, 32'h0000_0013);
    check("t6_legal", 32'(illegal), 32'd0);
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    check("t6_wrap", imem_addr, 32'h0);

    // 7: asynchronous reset in WAIT
    imem_gnt = 1'b1; step(); imem_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t7_valid", 32'(instr_valid), 32'd0);
    check("t7_req", 32'(imem_req), 32'd0);
    check("t7_addr", imem_addr, 32'h0);
    check("t7_ipc", instr_pc, 32'h0);
    check("t7_opcode", 32'(opcode), 32'h04);
    step();
    rst = 1'b1;
    step();
    check("t7_restart_req", 32'(imem_req), 32'd1);
    check("t7_restart_addr", imem_addr, 32'h0);

    // Randomized run against the scoreboard
    model_pc = 32'h0;
    exp_q.delete();
    refill();
    outst = 1'b0; out_addr = 32'd0; cnt = 0;
    req_prev = 1'b0; gnt_prev = 1'b0; addr_prev = 32'd0;
    sb_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (gnt_prev && req_prev) begin
        outst    = 1'b1;
        out_addr = addr_prev;
        cnt      = $urandom_range(1, 3);
      end
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (outst) begin
        if (cnt == 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(out_addr);
          outst       = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem_gnt    = (!outst && imem_req) ? ($urandom_range(0, 2) != 0) : 1'b0;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      if (redirect) begin
        if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else tgt = $urandom & 32'h0000_FFFF;
        redirect_pc = tgt;
        model_pc    = tgt & 32'hFFFF_FFFC;
        exp_q.delete();
      end
      refill();
      req_prev  = imem_req;
      addr_prev = imem_addr;
      gnt_prev  = imem_gnt;
    end
    step();
    sb_en = 1'b0;
    redirect = 1'b0;
    instr_ready = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    check("sb_progress", 32'(n_cons > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
